// File: rtl/fmaexparb_pkg.sv
// Shared types and sizes for the FMA product-exponent arbiter/pipeline.
// Holds exponent width/bias, tag width and the S1/S2 entry structs.
package fmaexparb_pkg;

    localparam int NE   = 11;
    localparam int BIAS = 1023;
    localparam int TAGW = 3;
    localparam int PW   = NE + 2;

    localparam logic [PW-1:0] BIAS_W = PW'(BIAS);

    typedef struct packed {
        logic            valid;
        logic [NE-1:0]   xe;
        logic [NE-1:0]   ye;
        logic            pzero;
        logic [TAGW-1:0] tag;
        logic            src;
    } s1_t;

    typedef struct packed {
        logic            valid;
        logic [PW-1:0]   pe;
        logic [TAGW-1:0] tag;
        logic            src;
    } s2_t;

endpackage

// File: rtl/fmaexparb_if.sv
// Handshake bundle between two requesters, the arbiter and the consumer.
// master: requesters/consumer side; slave: the fmaexparb block.
interface fmaexparb_if;
    import fmaexparb_pkg::*;

    logic            Flush;
    logic            Req0Valid;
    logic            Req0Ready;
    logic [NE-1:0]   Req0Xe;
    logic [NE-1:0]   Req0Ye;
    logic            Req0XZero;
    logic            Req0YZero;
    logic [TAGW-1:0] Req0Tag;
    logic            Req1Valid;
    logic            Req1Ready;
    logic [NE-1:0]   Req1Xe;
    logic [NE-1:0]   Req1Ye;
    logic            Req1XZero;
    logic            Req1YZero;
    logic [TAGW-1:0] Req1Tag;
    logic            PeValid;
    logic            PeReady;
    logic [PW-1:0]   Pe;
    logic [TAGW-1:0] PeTag;
    logic            PeSrc;
    logic            Busy;

    modport master (
        output Flush,
        output Req0Valid, Req0Xe, Req0Ye, Req0XZero, Req0YZero, Req0Tag,
        output Req1Valid, Req1Xe, Req1Ye, Req1XZero, Req1YZero, Req1Tag,
        output PeReady,
        input  Req0Ready, Req1Ready,
        input  PeValid, Pe, PeTag, PeSrc, Busy
    );

    modport slave (
        input  Flush,
        input  Req0Valid, Req0Xe, Req0Ye, Req0XZero, Req0YZero, Req0Tag,
        input  Req1Valid, Req1Xe, Req1Ye, Req1XZero, Req1YZero, Req1Tag,
        input  PeReady,
        output Req0Ready, Req1Ready,
        output PeValid, Pe, PeTag, PeSrc, Busy
    );

endinterface

// File: rtl/fmaexparb_fmaexpadd.sv
// Product exponent: Pe = pzero ? 0 : xe + ye - BIAS, modulo 2^(NE+2).
// Ports: xe, ye (NE), pzero (1) in; pe (NE+2) out.
module fmaexpadd
    import fmaexparb_pkg::*;
(
    input  logic [NE-1:0] xe,
    input  logic [NE-1:0] ye,
    input  logic          pzero,
    output logic [PW-1:0] pe
);

    logic [PW-1:0] sum;

    always_comb begin
        // Zero-extended add; a negative result shows up in two's complement.
        sum = {2'b00, xe} + {2'b00, ye} - BIAS_W;
        pe  = pzero ? '0 : sum;
    end

endmodule

// File: rtl/fmaexparb.sv
// Two-requester arbiter and two-stage product-exponent pipeline.
// Ports: clk, reset (sync, active-high), bus (fmaexparb_if.slave).
// Define FMAEXPARB_RR_EN for round-robin; otherwise requester 0 wins.
module fmaexparb
    import fmaexparb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    fmaexparb_if.slave  bus
);

    s1_t           s1;
    s2_t           s2;
    s1_t           new_s1;
    logic [PW-1:0] pe;
    logic          s1_adv;
    logic          s2_adv;
    logic          g0;
    logic          g1;
    logic          acc_ok;
    logic          accept;

`ifdef FMAEXPARB_RR_EN
    logic last_grant;
`endif

    assign s2_adv = !s2.valid | bus.PeReady;
    assign s1_adv = !s1.valid | s2_adv;
    assign acc_ok = s1_adv & !bus.Flush;

    always_comb begin
`ifdef FMAEXPARB_RR_EN
        // On contention grant whoever did not win last time.
        g0 = bus.Req0Valid & (!bus.Req1Valid | last_grant);
        g1 = bus.Req1Valid & (!bus.Req0Valid | !last_grant);
`else
        g0 = bus.Req0Valid;
        g1 = bus.Req1Valid & !bus.Req0Valid;
`endif
    end

    assign bus.Req0Ready = g0 & acc_ok;
    assign bus.Req1Ready = g1 & acc_ok;
    assign accept        = bus.Req0Ready | bus.Req1Ready;

    always_comb begin
        new_s1 = '0;
        new_s1.valid = 1'b1;
        if (bus.Req1Ready) begin
            new_s1.xe    = bus.Req1Xe;
            new_s1.ye    = bus.Req1Ye;
            new_s1.pzero = bus.Req1XZero | bus.Req1YZero;
            new_s1.tag   = bus.Req1Tag;
            new_s1.src   = 1'b1;
        end else begin
            new_s1.xe    = bus.Req0Xe;
            new_s1.ye    = bus.Req0Ye;
            new_s1.pzero = bus.Req0XZero | bus.Req0YZero;
            new_s1.tag   = bus.Req0Tag;
            new_s1.src   = 1'b0;
        end
    end

    fmaexpadd u_add (
        .xe    (s1.xe),
        .ye    (s1.ye),
        .pzero (s1.pzero),
        .pe    (pe)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else if (bus.Flush) begin
            s1.valid <= 1'b0;
            s2.valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2.valid <= s1.valid;
                // Payload only loads on a real entry so idle cycles keep it.
                if (s1.valid) begin
                    s2.pe  <= pe;
                    s2.tag <= s1.tag;
                    s2.src <= s1.src;
                end
            end
            if (s1_adv) begin
                if (accept) s1 <= new_s1;
                else        s1.valid <= 1'b0;
            end
        end
    end

`ifdef FMAEXPARB_RR_EN
    // accept is already low in a flush cycle, so flush leaves this alone.
    always_ff @(posedge clk) begin
        if (reset)       last_grant <= 1'b1;
        else if (accept) last_grant <= bus.Req1Ready;
    end
`endif

    assign bus.PeValid = s2.valid;
    assign bus.Pe      = s2.pe;
    assign bus.PeTag   = s2.tag;
    assign bus.PeSrc   = s2.src;
    assign bus.Busy    = s1.valid | s2.valid;

endmodule

// File: tb/tb_fmaexparb.sv
// Scoreboard bench for fmaexparb: accepts push hand-computed results,
// a monitor pops and compares on every PeValid&PeReady transfer.
module tb_fmaexparb;
    import fmaexparb_pkg::*;

    typedef struct packed {
        logic [PW-1:0]   pe;
        logic [TAGW-1:0] tag;
        logic            src;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fmaexparb_if bus();

    fmaexparb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    res_t sbq[$];
    res_t exp0;
    res_t exp1;
    res_t got;
    res_t want;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Issue side: every accepted request pushes its expected result.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.Req0Ready) sbq.push_back(exp0);
            if (bus.Req1Ready) sbq.push_back(exp1);
        end
    end

    // Result side: a flush-cycle transfer is ignored by the consumer.
    always @(negedge clk) begin
        if (!reset && bus.PeValid && bus.PeReady && !bus.Flush) begin
            total++;
            got = '{pe: bus.Pe, tag: bus.PeTag, src: bus.PeSrc};
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL result: unexpected pe=%0d tag=%0d src=%0d",
                         got.pe, got.tag, got.src);
            end else begin
                want = sbq.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL result: got pe=%0d tag=%0d src=%0d want pe=%0d tag=%0d src=%0d",
                             got.pe, got.tag, got.src,
                             want.pe, want.tag, want.src);
                end
            end
        end
    end

    task automatic set_req(input int r, input int xe, input int ye,
                           input bit xz, input bit yz, input int tag,
                           input int pe);
        if (r == 0) begin
            bus.Req0Xe    = NE'(xe);
            bus.Req0Ye    = NE'(ye);
            bus.Req0XZero = xz;
            bus.Req0YZero = yz;
            bus.Req0Tag   = TAGW'(tag);
            exp0 = '{pe: PW'(pe), tag: TAGW'(tag), src: 1'b0};
        end else begin
            bus.Req1Xe    = NE'(xe);
            bus.Req1Ye    = NE'(ye);
            bus.Req1XZero = xz;
            bus.Req1YZero = yz;
            bus.Req1Tag   = TAGW'(tag);
            exp1 = '{pe: PW'(pe), tag: TAGW'(tag), src: 1'b1};
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input int r, input int xe, input int ye,
                        input bit xz, input bit yz, input int tag,
                        input int pe);
        bit acc = 0;
        set_req(r, xe, ye, xz, yz, tag, pe);
        if (r == 0) bus.Req0Valid = 1'b1;
        else        bus.Req1Valid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = (r == 0) ? bus.Req0Ready : bus.Req1Ready;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no ready want ready on req%0d", r);
        end
        @(posedge clk);
        #1;
        if (r == 0) bus.Req0Valid = 1'b0;
        else        bus.Req1Valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc;
        bus.Flush = 1'b0;
        bus.PeReady = 1'b1;
        bus.Req0Valid = 1'b0;
        bus.Req1Valid = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pevalid", 32'(bus.PeValid), 0);
        chk("rst_pe", 32'(bus.Pe), 0);
        chk("rst_petag", 32'(bus.PeTag), 0);
        chk("rst_pesrc", 32'(bus.PeSrc), 0);
        chk("rst_busy", 32'(bus.Busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single request and latency
        set_req(0, 1023, 1023, 0, 0, 5, 1023);
        bus.Req0Valid = 1'b1;
        @(negedge clk);
        chk("t1_ready", 32'(bus.Req0Ready), 1);
        @(posedge clk);
        #1;
        bus.Req0Valid = 1'b0;
        @(negedge clk);
        chk("t1_lat_early", 32'(bus.PeValid), 0);
        @(negedge clk);
        chk("t1_lat_valid", 32'(bus.PeValid), 1);
        @(posedge clk);
        #1;
        wait_drain();

        // Wrap-around and zero kill, back to back on requester 1
        send(1, 1, 1, 0, 0, 2, 7171);
        send(1, 2047, 2047, 1, 0, 3, 0);
        wait_drain();

        // Contention right after reset release
        reset = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_req(0, 1000, 30, 0, 0, 1, 7);
        set_req(1, 1023, 100, 0, 0, 6, 100);
        bus.Req0Valid = 1'b1;
        bus.Req1Valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef FMAEXPARB_RR_EN
            chk("rr_grant0", 32'(bus.Req0Ready), 32'((i % 2) == 0));
            chk("rr_grant1", 32'(bus.Req1Ready), 32'((i % 2) == 1));
`else
            chk("fp_grant0", 32'(bus.Req0Ready), 1);
            chk("fp_grant1", 32'(bus.Req1Ready), 0);
`endif
        end
        @(posedge clk);
        #1;
        bus.Req0Valid = 1'b0;
        bus.Req1Valid = 1'b0;
        wait_drain();

        // Backpressure: only two entries fit
        bus.PeReady = 1'b0;
        set_req(0, 1024, 1030, 0, 0, 4, 1031);
        bus.Req0Valid = 1'b1;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.Req0Ready) nacc++;
            if (i >= 2) chk("bp_pe_hold", 32'(bus.Pe), 1031);
        end
        chk("bp_accepts", 32'(nacc), 2);
        chk("bp_ready_low", 32'(bus.Req0Ready), 0);
        chk("bp_pevalid", 32'(bus.PeValid), 1);
        @(posedge clk);
        #1;
        bus.Req0Valid = 1'b0;
        bus.PeReady = 1'b1;
        wait_drain();
        @(negedge clk);
        chk("bp_idle", 32'(bus.Busy), 0);
        @(posedge clk);
        #1;

        // Flush with both stages full and a pending request
        set_req(0, 1030, 1023, 0, 0, 7, 1030);
        bus.Req0Valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.Flush = 1'b1;
        @(negedge clk);
        chk("fl_no_accept", 32'(bus.Req0Ready), 0);
        chk("fl_busy_before", 32'(bus.Busy), 1);
        @(posedge clk);
        #1;
        bus.Flush = 1'b0;
        bus.Req0Valid = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("fl_pevalid", 32'(bus.PeValid), 0);
        chk("fl_busy", 32'(bus.Busy), 0);
        @(posedge clk);
        #1;

        // Still works after flush
        send(1, 1023, 1023, 0, 0, 2, 1023);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
